// File: rtl/vending_ctrl.sv
// vending_ctrl: two-item vending session FSM with coin accumulation, timed vend and refund phases
module vending_ctrl #(
  parameter int PRICE_ONE = 5,
  parameter int PRICE_TWO = 10,
  parameter int VEND_CYCLES = 100,
  parameter int CHANGE_CYCLES = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       cancel,
  input  logic       coin_one,
  input  logic       coin_five,
  input  logic       sel_one,
  input  logic       sel_two,
  output logic       op_start,
  output logic [5:0] coin_val,
  output logic       buy_one,
  output logic       buy_two,
  output logic       charge_ind
);
  localparam int MAXC = VEND_CYCLES > CHANGE_CYCLES ? VEND_CYCLES : CHANGE_CYCLES;
  localparam int CW = MAXC > 1 ? $clog2(MAXC) : 1;
  typedef enum logic [1:0] {IDLE, ACCEPT, VEND, CHANGE} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [5:0] val_n;
  logic op_n, b1_n, b2_n, ch_n;
  logic [6:0] sum;
  logic ok_one, ok_two;
  assign sum = 7'(coin_val) + 7'(coin_one) + (coin_five ? 7'd5 : 7'd0);
  assign ok_one = sel_one && coin_val >= 6'(PRICE_ONE);
  assign ok_two = sel_two && coin_val >= 6'(PRICE_TWO);
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    val_n = coin_val;
    op_n = op_start;
    b1_n = buy_one;
    b2_n = buy_two;
    ch_n = charge_ind;
    unique case (state)
      IDLE: begin
        {op_n, val_n, b1_n, b2_n, ch_n} = '0;
        if (start) begin
          state_n = ACCEPT;
          op_n = 1'b1;
          cnt_n = '0;
        end
      end
      ACCEPT: begin
        cnt_n = '0;
        if (cancel) begin
          state_n = coin_val != 6'd0 ? CHANGE : IDLE;
          ch_n = coin_val != 6'd0;
          op_n = coin_val != 6'd0;
        end else if (ok_one) begin
          state_n = VEND;
          val_n = coin_val - 6'(PRICE_ONE);
          b1_n = 1'b1;
        end else if (ok_two) begin
          state_n = VEND;
          val_n = coin_val - 6'(PRICE_TWO);
          b2_n = 1'b1;
        end else begin
          val_n = sum > 7'd63 ? 6'd63 : sum[5:0];
        end
      end
      VEND: begin
        cnt_n = cnt + 1'b1;
        if (cnt == CW'(VEND_CYCLES - 1)) begin
          state_n = ACCEPT;
          cnt_n = '0;
          b1_n = 1'b0;
          b2_n = 1'b0;
        end
      end
      CHANGE: begin
        cnt_n = cnt + 1'b1;
        if (cnt == CW'(CHANGE_CYCLES - 1)) begin
          state_n = IDLE;
          cnt_n = '0;
          {op_n, val_n, ch_n} = '0;
        end
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      {op_start, coin_val, buy_one, buy_two, charge_ind} <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      op_start <= op_n;
      coin_val <= val_n;
      buy_one <= b1_n;
      buy_two <= b2_n;
      charge_ind <= ch_n;
    end
  end
endmodule

// File: tb/tb_vending_ctrl.sv
// tb_vending_ctrl: directed scenarios checked against a timer-based session model every cycle
module tb_vending_ctrl;
  localparam int P1 = 5, P2 = 10, V = 100, C = 100;
  localparam logic [5:0] ST = 6'd1, CA = 6'd2, C1 = 6'd4, C5 = 6'd8, S1 = 6'd16, S2 = 6'd32;
  logic clk = 1'b0, rst = 1'b1;
  logic start = 0, cancel = 0, coin_one = 0, coin_five = 0, sel_one = 0, sel_two = 0;
  logic op_start, buy_one, buy_two, charge_ind;
  logic [5:0] coin_val;
  int n_chk = 0, n_fail = 0;
  bit armed = 0;
  bit m_on;
  int m_bal, m_buy, m_vend_left, m_ref_left;

  vending_ctrl #(.PRICE_ONE(P1), .PRICE_TWO(P2), .VEND_CYCLES(V), .CHANGE_CYCLES(C)) dut (
    .clk(clk), .rst(rst), .start(start), .cancel(cancel), .coin_one(coin_one),
    .coin_five(coin_five), .sel_one(sel_one), .sel_two(sel_two), .op_start(op_start),
    .coin_val(coin_val), .buy_one(buy_one), .buy_two(buy_two), .charge_ind(charge_ind)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endtask

  // A session is either idle, taking coins, or running one of two countdown timers.
  always @(posedge clk) begin
    if (rst) begin
      armed <= 1;
      m_on = 0; m_bal = 0; m_buy = 0; m_vend_left = 0; m_ref_left = 0;
    end else if (m_vend_left > 0) begin
      m_vend_left--;
      if (m_vend_left == 0) m_buy = 0;
    end else if (m_ref_left > 0) begin
      m_ref_left--;
      if (m_ref_left == 0) begin m_on = 0; m_bal = 0; end
    end else if (!m_on) begin
      if (start) begin m_on = 1; m_bal = 0; end
    end else if (cancel) begin
      if (m_bal > 0) m_ref_left = C; else m_on = 0;
    end else if (sel_one && m_bal >= P1) begin
      m_bal -= P1; m_buy = 1; m_vend_left = V;
    end else if (sel_two && m_bal >= P2) begin
      m_bal -= P2; m_buy = 2; m_vend_left = V;
    end else begin
      m_bal = m_bal + int'(coin_one) + 5 * int'(coin_five);
      if (m_bal > 63) m_bal = 63;
    end
  end

  always @(negedge clk) if (armed) begin
    chk("op_start", 8'(op_start), 8'(m_on));
    chk("coin_val", 8'(coin_val), 8'(m_bal));
    chk("buy_one", 8'(buy_one), 8'(m_buy == 1));
    chk("buy_two", 8'(buy_two), 8'(m_buy == 2));
    chk("charge_ind", 8'(charge_ind), 8'(m_ref_left > 0));
    chk("exclusive", 8'(int'(buy_one) + int'(buy_two) + int'(charge_ind) <= 1), 8'd1);
  end

  task automatic ev(input logic [5:0] v);
    @(negedge clk);
    {sel_two, sel_one, coin_five, coin_one, cancel, start} = v;
    @(negedge clk);
    {sel_two, sel_one, coin_five, coin_one, cancel, start} = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rst_pulse();
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
  endtask

  task automatic all_zero(input string nm);
    chk(nm, {op_start, coin_val, buy_one, buy_two, charge_ind}, 8'd0);
  endtask

  initial begin
    idle(2);
    rst = 0;
    all_zero("reset_outputs");
    ev(ST);
    chk("start_op", 8'(op_start), 8'd1);
    chk("start_val", 8'(coin_val), 8'd0);
    for (int i = 1; i <= 5; i++) begin
      ev(C1);
      chk("coin_step", 8'(coin_val), 8'(i));
    end
    ev(C5); ev(C1); ev(C1);
    chk("bal12", 8'(coin_val), 8'd12);
    ev(S1);
    chk("vend_b1", 8'(buy_one), 8'd1);
    chk("vend_val", 8'(coin_val), 8'd7);
    idle(V - 1);
    chk("vend_last", 8'(buy_one), 8'd1);
    idle(1);
    chk("vend_done", 8'(buy_one), 8'd0);
    chk("vend_left", 8'(coin_val), 8'd7);
    chk("vend_op", 8'(op_start), 8'd1);
    ev(S2);
    chk("poor_b2", 8'(buy_two), 8'd0);
    chk("poor_val", 8'(coin_val), 8'd7);
    ev(C5);
    ev(S1 | S2);
    chk("both_b1", 8'(buy_one), 8'd1);
    chk("both_b2", 8'(buy_two), 8'd0);
    chk("both_val", 8'(coin_val), 8'd7);
    idle(V);
    ev(CA);
    chk("chg_ind", 8'(charge_ind), 8'd1);
    chk("chg_val", 8'(coin_val), 8'd7);
    idle(C - 1);
    chk("chg_last", 8'(charge_ind), 8'd1);
    idle(1);
    all_zero("chg_done");
    ev(ST);
    ev(CA);
    chk("cancel0_op", 8'(op_start), 8'd0);
    ev(ST);
    repeat (12) ev(C5);
    chk("bal60", 8'(coin_val), 8'd60);
    ev(C5);
    chk("sat63", 8'(coin_val), 8'd63);
    ev(CA);
    idle(C);
    ev(ST); ev(C5); ev(C5);
    ev(C1 | C5);
    chk("both_coins", 8'(coin_val), 8'd16);
    ev(S1 | C1);
    chk("drop_b1", 8'(buy_one), 8'd1);
    chk("drop_val", 8'(coin_val), 8'd11);
    idle(V);
    ev(S1);
    idle(49);
    rst_pulse();
    all_zero("rst_vend");
    ev(ST); ev(C5); ev(CA);
    idle(49);
    chk("pre_rst_chg", 8'(charge_ind), 8'd1);
    rst_pulse();
    all_zero("rst_chg");
    ev(ST);
    chk("reopen_op", 8'(op_start), 8'd1);
    chk("reopen_val", 8'(coin_val), 8'd0);
    idle(5);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
